// File: rtl/key_conditioner.sv
// Per-key synchronizer, debouncer and press/repeat/release FSM.
// Converts bouncing active-low buttons into clean single-cycle command pulses.
module key_conditioner #(
    parameter int                N_KEYS          = 3,
    parameter int                DEBOUNCE_CYCLES = 500000,
    parameter int                REPEAT_DELAY    = 25000000,
    parameter int                REPEAT_PERIOD   = 5000000,
    parameter logic [N_KEYS-1:0] REPEAT_EN       = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] in_key,
    output logic [N_KEYS-1:0] out_key,
    output logic [N_KEYS-1:0] out_held,
    output logic [N_KEYS-1:0] out_release
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                         : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD_WAIT,
        HELD_RPT
    } state_e;

    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
        logic          sync1_q, sync2_q;
        logic          db_q, db_d;
        logic [DW-1:0] db_cnt_q, db_cnt_d;
        state_e        state_q, state_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        logic          key_q, key_d;
        logic          rel_q, rel_d;
        logic          held_q, held_d;

        // db_q is the accepted level, 1 = pressed
        always_comb begin
            db_d     = db_q;
            db_cnt_d = '0;
            if (~sync2_q != db_q) begin
                if (db_cnt_q == DB_LAST) begin
                    db_d = ~db_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

        always_comb begin
            state_d = state_q;
            rcnt_d  = rcnt_q;
            key_d   = 1'b0;
            rel_d   = 1'b0;
            held_d  = held_q;
            unique case (state_q)
                IDLE: begin
                    rcnt_d = '0;
                    if (db_q) begin
                        state_d = HELD_WAIT;
                        key_d   = 1'b1;
                        held_d  = 1'b1;
                    end
                end
                HELD_WAIT: begin
                    if (!db_q) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                        held_d  = 1'b0;
                        rcnt_d  = '0;
                    end else if (rcnt_q == DLY_LAST) begin
                        // without repeat enabled the count parks here
                        if (REPEAT_EN[gi]) begin
                            state_d = HELD_RPT;
                            key_d   = 1'b1;
                            rcnt_d  = '0;
                        end
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                HELD_RPT: begin
                    if (!db_q) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                        held_d  = 1'b0;
                        rcnt_d  = '0;
                    end else if (rcnt_q == PER_LAST) begin
                        key_d  = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rcnt_d  = '0;
                    held_d  = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_q  <= 1'b1;
                sync2_q  <= 1'b1;
                db_q     <= 1'b0;
                db_cnt_q <= '0;
                state_q  <= IDLE;
                rcnt_q   <= '0;
                key_q    <= 1'b0;
                rel_q    <= 1'b0;
                held_q   <= 1'b0;
            end else begin
                sync1_q  <= in_key[gi];
                sync2_q  <= sync1_q;
                db_q     <= db_d;
                db_cnt_q <= db_cnt_d;
                state_q  <= state_d;
                rcnt_q   <= rcnt_d;
                key_q    <= key_d;
                rel_q    <= rel_d;
                held_q   <= held_d;
            end
        end

        assign out_key[gi]     = key_q;
        assign out_held[gi]    = held_q;
        assign out_release[gi] = rel_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat settings.
module tb_key_conditioner;

    logic       clk;
    logic       rst;
    logic [2:0] in_key;
    logic [2:0] out_key;
    logic [2:0] out_held;
    logic [2:0] out_release;

    int n_cmp;
    int n_err;

    key_conditioner #(
        .N_KEYS         (3),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_EN      (3'b001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_key     (in_key),
        .out_key    (out_key),
        .out_held   (out_held),
        .out_release(out_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int e,
                       input logic [2:0] obs, input logic [2:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s @%0d: observed %b expected %b", tag, e, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input int e,
                           input logic [2:0] k, input logic [2:0] h,
                           input logic [2:0] r);
        chk({tag, "_key"}, e, out_key, k);
        chk({tag, "_held"}, e, out_held, h);
        chk({tag, "_rel"}, e, out_release, r);
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_rpt(input int off);
        int offs[10] = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34};
        for (int i = 0; i < 10; i++)
            if (offs[i] == off) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [2:0] ek, eh, er;
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        in_key = 3'b111;

        edge_wait();
        edge_wait();
        chk_all("reset", 0, 3'b000, 3'b000, 3'b000);
        #2 rst = 1'b0;

        // clean press/release on key 1
        for (int e = 1; e <= 30; e++) begin
            in_key = (e <= 20) ? 3'b101 : 3'b111;
            edge_wait();
            ek = (e == 7) ? 3'b010 : 3'b000;
            eh = (e >= 7 && e < 27) ? 3'b010 : 3'b000;
            er = (e == 27) ? 3'b010 : 3'b000;
            chk_all("clean", e, ek, eh, er);
        end

        // bounce, stable press, auto-repeat, release colliding with repeat
        for (int e = 1; e <= 82; e++) begin
            if (e <= 30)
                in_key = (((e - 1) / 3) % 2 == 0) ? 3'b110 : 3'b111;
            else
                in_key = (e <= 67) ? 3'b110 : 3'b111;
            edge_wait();
            ek = (e >= 37 && is_rpt(e - 37)) ? 3'b001 : 3'b000;
            eh = (e >= 37 && e < 74) ? 3'b001 : 3'b000;
            er = (e == 74) ? 3'b001 : 3'b000;
            chk_all("rpt", e, ek, eh, er);
        end

        // all keys pressed together
        for (int e = 1; e <= 9; e++) begin
            in_key = 3'b000;
            edge_wait();
            ek = (e == 7) ? 3'b111 : 3'b000;
            eh = (e >= 7) ? 3'b111 : 3'b000;
            chk_all("simul", e, ek, eh, 3'b000);
        end

        // asynchronous reset while held
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_all("rst_async", 0, 3'b000, 3'b000, 3'b000);
        @(posedge clk);
        #1 chk_all("rst_hold", 1, 3'b000, 3'b000, 3'b000);
        @(posedge clk);
        #3 rst = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            edge_wait();
            ek = (e == 7) ? 3'b111 : 3'b000;
            eh = (e >= 7) ? 3'b111 : 3'b000;
            chk_all("after_rst", e, ek, eh, 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
